// File: rtl/fp_norm24.sv
// fp_norm24 -- post-add normalizer for the FP32 datapath.
//
// Takes the raw mantissa sum (carry + MW bits), its biased exponent and sign.
// It moves the leading one to bit MW-1, adjusts the exponent, and flags
// zero, overflow and underflow. The block is a two-stage pipeline with a
// valid/ready handshake on both sides. Rounding is done by the next stage.
//
// Ports
//   clk        in   1     clock, all state on rising edge
//   reset      in   1     synchronous, active-high
//   in_valid   in   1     input beat valid
//   in_ready   out  1     beat accepted this cycle (combinational from out_ready)
//   in_sign    in   1     sign of result
//   in_exp     in   EW    biased exponent of unnormalized sum
//   in_mant    in   MW+1  raw sum, bit MW = carry-out
//   out_valid  out  1     output beat valid
//   out_ready  in   1     downstream accepts beat
//   out_sign   out  1     sign, passed through
//   out_exp    out  EW    adjusted exponent
//   out_mant   out  MW    normalized mantissa
//   out_zero   out  1     exact zero input
//   out_ovf    out  1     exponent overflow, forced to infinity
//   out_unf    out  1     underflow, flushed to zero

module fp_norm24 #(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp,
    input  logic [MW:0]   in_mant,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [EW-1:0] out_exp,
    output logic [MW-1:0] out_mant,
    output logic          out_zero,
    output logic          out_ovf,
    output logic          out_unf
);

    localparam int LZW = $clog2(MW + 1);

    // Leading-zero count of an MW-bit field; returns MW for an all-zero field.
    // The loop runs low to high, so the highest set bit decides the result.
    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (v[i]) n = LZW'(MW - 1 - i);
        end
        return n;
    endfunction

    logic adv1, adv2;

    logic           s1_valid, s1_sign, s1_carry, s1_zero;
    logic [EW-1:0]  s1_exp;
    logic [MW:0]    s1_mant;
    logic [LZW-1:0] s1_lz;

    logic           s2_valid, s2_sign, s2_zero, s2_ovf, s2_unf;
    logic [EW-1:0]  s2_exp;
    logic [MW-1:0]  s2_mant;

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_carry <= 1'b0;
            s1_zero  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_lz    <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            s1_sign  <= in_sign;
            s1_carry <= in_mant[MW];
            s1_zero  <= (in_mant == '0);
            s1_exp   <= in_exp;
            s1_mant  <= in_mant;
            s1_lz    <= lzc(in_mant[MW-1:0]);
        end
    end

    // Exponent compares are done one bit wider so exp+1 and exp-vs-lz never wrap.
    logic [EW:0]    e_wide, e_inc, lz_wide, e_max;
    logic [EW-1:0]  n_exp;
    logic [MW-1:0]  n_mant;
    logic           n_zero, n_ovf, n_unf;

    assign e_wide  = {1'b0, s1_exp};
    assign e_inc   = e_wide + 1'b1;
    assign lz_wide = {{(EW + 1 - LZW){1'b0}}, s1_lz};
    assign e_max   = {1'b0, {EW{1'b1}}};

    always_comb begin
        n_exp  = '0;
        n_mant = '0;
        n_zero = 1'b0;
        n_ovf  = 1'b0;
        n_unf  = 1'b0;
        if (s1_zero) begin
            n_zero = 1'b1;
        end else if (s1_carry) begin
            if (e_inc >= e_max) begin
                n_exp = '1;
                n_ovf = 1'b1;
            end else begin
                n_exp  = e_inc[EW-1:0];
                n_mant = s1_mant[MW:1];
            end
        end else if (e_wide > lz_wide) begin
            n_exp  = s1_exp - EW'(s1_lz);
            n_mant = s1_mant[MW-1:0] << s1_lz;
        end else begin
            n_unf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_exp   <= '0;
            s2_mant  <= '0;
            s2_zero  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_unf   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_exp   <= n_exp;
            s2_mant  <= n_mant;
            s2_zero  <= n_zero;
            s2_ovf   <= n_ovf;
            s2_unf   <= n_unf;
        end
    end

    assign out_valid = s2_valid;
    assign out_sign  = s2_sign;
    assign out_exp   = s2_exp;
    assign out_mant  = s2_mant;
    assign out_zero  = s2_zero;
    assign out_ovf   = s2_ovf;
    assign out_unf   = s2_unf;

endmodule

// File: tb/tb_fp_norm24.sv
// Testbench for fp_norm24: directed vectors with a scoreboard queue and a
// separate monitor that pops and compares on every output transfer.

module tb_fp_norm24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [23:0] out_mant;
    logic        out_zero, out_ovf, out_unf;

    fp_norm24 #(.MW(24), .EW(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
        .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] res;   // {sign, exp, mant, zero, ovf, unf}
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: sampled on the falling edge, a transfer happens at the next rising edge.
    initial begin
        logic [35:0] snap, hold;
        bit          hold_v;
        exp_t        e;
        hold_v = 0;
        hold = '0;
        forever begin
            @(negedge clk);
            snap = {out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf};
            if (!reset && hold_v && out_valid) begin
                n_cmp++;
                if (snap !== hold) begin
                    n_err++;
                    $display("FAIL stall_hold: got %h want %h", snap, hold);
                end
            end
            hold_v = !reset && out_valid && !out_ready;
            hold = snap;
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got %h, nothing expected", snap);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (snap !== e.res) begin
                        n_err++;
                        $display("FAIL beat: got %h want %h", snap, e.res);
                    end
                    if (e.lat) begin
                        n_cmp++;
                        if (cyc - e.acc != 2) begin
                            n_err++;
                            $display("FAIL latency: got %0d want 2", cyc - e.acc);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Offer one beat; the expected result is pushed at the moment it is accepted.
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input logic [7:0] xe, input logic [23:0] xm,
                        input logic [2:0] xf, input bit lat);
        exp_t x;
        int   w;
        bit   done;
        in_valid = 1'b1;
        in_sign = s;
        in_exp = e;
        in_mant = m;
        done = 0;
        w = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                x.res = {s, xe, xm, xf};
                x.acc = cyc;
                x.lat = lat;
                sb.push_back(x);
                done = 1;
            end else if (++w > 50) begin
                n_err++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, want 1", w);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding, want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // flags order {zero, ovf, unf}
        send(1'b0, 8'd127, 25'h0800000, 8'd127, 24'h800000, 3'b000, 1);
        drain();
        send(1'b0, 8'd127, 25'h1800000, 8'd128, 24'hC00000, 3'b000, 0);
        send(1'b1, 8'd254, 25'h1000000, 8'd255, 24'h000000, 3'b010, 0);
        send(1'b0, 8'd100, 25'h0000001, 8'd77,  24'h800000, 3'b000, 0);
        send(1'b0, 8'd23,  25'h0000001, 8'd0,   24'h000000, 3'b001, 0);
        send(1'b1, 8'd50,  25'h0000000, 8'd0,   24'h000000, 3'b100, 0);
        send(1'b0, 8'd24,  25'h0000001, 8'd1,   24'h800000, 3'b000, 0);
        send(1'b0, 8'd253, 25'h1FFFFFF, 8'd254, 24'hFFFFFF, 3'b000, 0);
        send(1'b0, 8'd255, 25'h1000000, 8'd255, 24'h000000, 3'b010, 0);
        send(1'b1, 8'd0,   25'h0800000, 8'd0,   24'h000000, 3'b001, 0);
        send(1'b0, 8'd5,   25'h0400000, 8'd4,   24'h800000, 3'b000, 0);
        send(1'b0, 8'd130, 25'h0123456, 8'd127, 24'h91A2B0, 3'b000, 0);
        send(1'b0, 8'd10,  25'h1000001, 8'd11,  24'h800000, 3'b000, 0);
        send(1'b0, 8'd0,   25'h0000000, 8'd0,   24'h000000, 3'b100, 0);
        drain();

        // Stream of 8 beats with the output stalled in relative cycles 3..6.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(1'b0, 8'(60 + i), 25'h0800000 | 25'(i),
                         8'(60 + i), 24'h800000 | 24'(i), 3'b000, 0);
            end
            begin
                for (int t = 0; t < 12; t++) begin
                    out_ready = !(t >= 3 && t <= 6);
                    @(negedge clk);
                    if (t >= 3 && t <= 6) check("stall_in_ready", 64'(in_ready), 64'd0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(1'b0, 8'd90, 25'h0800000, 8'd90, 24'h800000, 3'b000, 0);
        send(1'b0, 8'd91, 25'h0800000, 8'd91, 24'h800000, 3'b000, 0);
        reset = 1'b1;
        in_valid = 1'b1;
        in_exp = 8'd92;
        in_mant = 25'h0800000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(1'b1, 8'd140, 25'h0200000, 8'd138, 24'h800000, 3'b000, 1);
        drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
